// File: rtl/dff_seq_checker.sv
// Serial stimulus sequencer and checker for a single D flip-flop under test.
// Drives a fixed pattern on D and checks that Q follows one cycle later and that Qb = ~Q.
module dff_seq_checker #(
  parameter int unsigned PATTERN_LEN = 16,
  parameter logic [31:0] PATTERN     = 32'h0000_A5C3
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  output logic       Dut_D,
  input  logic       Dut_Q,
  input  logic       Dut_Qb,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [5:0] Err_cnt,
  output logic [5:0] Fail_idx
);

  localparam int unsigned IDX_W = 6;
  localparam logic [IDX_W-1:0] NO_FAIL  = 6'h3F;
  localparam logic [IDX_W-1:0] ERR_MAX  = 6'h3F;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_LEN - 1);
  // Zero-extended so a 6-bit index never runs off the end of the pattern.
  localparam logic [63:0]      PAT_EXT  = {32'd0, PATTERN};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cidx_q, cidx_d;
  logic [IDX_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic             dut_d_q, dut_d_d;
  logic             exp_q, exp_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             bit_fail;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dut_d_d = dut_d_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    // Check pipeline: remember what is on D now, compare Q/Qb against it one edge later.
    exp_d    = dut_d_q;
    vld_d    = (state_q == S_RUN);
    cidx_d   = idx_q;
    bit_fail = vld_q && ((Dut_Q != exp_q) || (Dut_Qb != ~exp_q));

    if (bit_fail) begin
      if (err_q != ERR_MAX) err_d = err_q + 6'd1;
      if (fidx_q == NO_FAIL) fidx_d = cidx_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          dut_d_d = PAT_EXT[0];
          idx_d   = '0;
          err_d   = '0;
          fidx_d  = NO_FAIL;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == LAST_IDX) begin
          dut_d_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          dut_d_d = PAT_EXT[idx_q + 6'd1];
        end
      end
      S_DRAIN: begin
        // The last bit's compare lands on this edge.
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cidx_q  <= '0;
      err_q   <= '0;
      fidx_q  <= NO_FAIL;
      dut_d_q <= 1'b0;
      exp_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cidx_q  <= cidx_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      dut_d_q <= dut_d_d;
      exp_q   <= exp_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign Dut_D    = dut_d_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Pass     = pass_q;
  assign Err_cnt  = err_q;
  assign Fail_idx = fidx_q;

endmodule
